ofs_plat_host_chan_axi_rd_arb: RTL and testbench
================================================

Name: ofs_plat_host_chan_axi_rd_arb

Overview:
Shares one host-memory AXI read channel (AR/R) among N_PORTS AFU read sources. Sources present AR requests. A round-robin arbiter forwards each request through one output register stage, appending the source port index to the high bits of the ARID. R beats returning from the host channel are routed back to the owning port by decoding those ARID bits. Per-port outstanding-burst credit counters bound in-flight traffic so that no single source can monopolise the host channel's read tracking.

Parameters:
N_PORTS, 4, number of read sources (2..16).
ADDR_WIDTH, 64, byte address width.
DATA_WIDTH, 512, R data width.
ID_WIDTH, 8, source-side ARID/RID width.
LEN_WIDTH, 8, AXI burst length field width.
MAX_OUTSTANDING, 16, maximum in-flight bursts per port (1..255).

Derived parameter: PW = $clog2(N_PORTS) (minimum 1).

Ports:
clk  in  1  host-channel clock; all logic is on this clock.
reset_n  in  1  asynchronous active-low reset.
src_ar_valid  in  N_PORTS  per-port AR valid.
src_ar_ready  out  N_PORTS  per-port AR ready.
src_ar_addr  in  N_PORTS*ADDR_WIDTH  per-port ARADDR.
src_ar_id  in  N_PORTS*ID_WIDTH  per-port ARID.
src_ar_len  in  N_PORTS*LEN_WIDTH  per-port ARLEN.
sink_ar_valid  out  1  AR valid to host channel.
sink_ar_ready  in  1  AR ready from host channel.
sink_ar_addr  out  ADDR_WIDTH  forwarded ARADDR.
sink_ar_id  out  PW+ID_WIDTH  {port index, source ARID}.
sink_ar_len  out  LEN_WIDTH  forwarded ARLEN.
sink_r_valid  in  1  R valid from host channel.
sink_r_ready  out  1  R ready to host channel.
sink_r_data  in  DATA_WIDTH  R data.
sink_r_id  in  PW+ID_WIDTH  returned RID.
sink_r_last  in  1  last beat of burst.
src_r_valid  out  N_PORTS  per-port R valid.
src_r_ready  in  N_PORTS  per-port R ready.
src_r_data  out  DATA_WIDTH  R data, broadcast to all ports.
src_r_id  out  ID_WIDTH  low ID_WIDTH bits of sink_r_id, broadcast.
src_r_last  out  1  sink_r_last, broadcast.
idle  out  1  all credit counters are zero and the AR output register is empty.
err_bad_rid  out  1  sticky flag: an R beat arrived with a port index >= N_PORTS.

Behaviour:
- Reset values:
  - sink_ar_valid=0.
  - All credit counters = 0.
  - Round-robin pointer = 0.
  - err_bad_rid = 0.
  - idle = 1.
  - AR output register data is don't-care.
- Eligibility: port p is eligible when src_ar_valid[p]=1 AND cnt[p] < MAX_OUTSTANDING.
- Load condition: load = !sink_ar_valid || sink_ar_ready, i.e. the output register is empty or draining this cycle.
- Grant:
  - Combinational; one-hot; only asserted when load=1.
  - Selects the first eligible port scanning upward from the pointer, wrapping from N_PORTS-1 to 0.
  - src_ar_ready[p] = grant[p]. Ready may depend on valid.
- AR handshake on port p (grant[p] with valid):
  - The output register captures {p, id}, addr and len.
  - sink_ar_valid=1 on the next cycle.
  - The pointer becomes (p+1) mod N_PORTS.
  - With no grant, the pointer is held.
- Output register behaviour:
  - When sink_ar_valid && !sink_ar_ready, the register holds all fields stable and grants nothing.
  - When sink_ar_ready=1 with no eligible port, sink_ar_valid drops to 0.
  - Back-to-back grants on consecutive cycles are supported, giving full throughput.
- Latency: source AR handshake to sink_ar_valid is 1 cycle. The R path is combinational with 0 cycles of latency.
- Credit counter cnt[p] (8 bits):
  - Increments on the AR handshake for port p.
  - Decrements on an R handshake with sink_r_last=1 and decoded index p.
  - Increment and decrement in the same cycle leave the value unchanged.
  - A port at MAX_OUTSTANDING is ineligible but keeps its pointer position.
  - Underflow is impossible by construction. A debug assertion covers it in simulation.
- R routing:
  - idx = sink_r_id[PW+ID_WIDTH-1:ID_WIDTH].
  - src_r_valid[p] = sink_r_valid && idx==p.
  - sink_r_ready = src_r_ready[idx] for idx < N_PORTS.
  - Backpressure on one port stalls the whole R channel; the block does not reorder beats.
- Bad index (idx >= N_PORTS, possible only when N_PORTS is not a power of 2):
  - sink_r_ready=1, so the beat is discarded.
  - No src_r_valid is raised.
  - err_bad_rid is set and stays set until reset.
- Reset mid-operation: counters and the register clear asynchronously and in-flight bursts are forgotten. The host channel must be reset in the same domain; the block does not drain or track across reset.
- idle is registered from the next-state values, so it carries no combinational path.

Test Plan:
- Single port: port 1 issues addr 0x1000, id 0x05, len 3 → sink_ar_id={1,0x05} one cycle later. cnt[1]=1 until the 4th R beat with last, then 0 and idle=1.
- Fairness: all 4 ports hold valid continuously with sink_ar_ready=1 → grants are 0,1,2,3,0,1…, one per cycle, with no bubbles.
- Credit limit: MAX_OUTSTANDING=2, port 0 issues 3 requests with no responses → third request is stalled (src_ar_ready[0]=0) while port 2 is still granted. One R last for port 0 → third request is granted the next cycle.
- Backpressure: sink_ar_ready=0 for 5 cycles with a request in the register → addr/id/len stay stable, no src_ar_ready is asserted, and the pointer is unchanged.
- R routing: interleaved beats with RIDs {2,0x11} and {0,0x22}; src_r_ready[2]=0 → sink_r_ready=0 during the port-2 beat and src_r_valid[0] is not asserted for that beat.
- Bad RID: N_PORTS=3, beat with idx=3 → accepted, dropped, err_bad_rid=1 and held; asserting reset_n mid-burst clears counters, err_bad_rid and sink_ar_valid immediately.

Source files
------------

// File: rtl/ofs_plat_host_chan_axi_rd_arb.sv
// Round-robin arbiter sharing one host AXI read channel among N_PORTS sources.
// The port index is tagged onto ARID high bits, and R beats are routed back by that tag.
module ofs_plat_host_chan_axi_rd_arb #(
  parameter int unsigned N_PORTS         = 4,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 16,
  localparam int unsigned PW             = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [N_PORTS-1:0]            src_ar_valid,
  output logic [N_PORTS-1:0]            src_ar_ready,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] src_ar_addr,
  input  logic [N_PORTS*ID_WIDTH-1:0]   src_ar_id,
  input  logic [N_PORTS*LEN_WIDTH-1:0]  src_ar_len,
  output logic                          sink_ar_valid,
  input  logic                          sink_ar_ready,
  output logic [ADDR_WIDTH-1:0]         sink_ar_addr,
  output logic [PW+ID_WIDTH-1:0]        sink_ar_id,
  output logic [LEN_WIDTH-1:0]          sink_ar_len,
  input  logic                          sink_r_valid,
  output logic                          sink_r_ready,
  input  logic [DATA_WIDTH-1:0]         sink_r_data,
  input  logic [PW+ID_WIDTH-1:0]        sink_r_id,
  input  logic                          sink_r_last,
  output logic [N_PORTS-1:0]            src_r_valid,
  input  logic [N_PORTS-1:0]            src_r_ready,
  output logic [DATA_WIDTH-1:0]         src_r_data,
  output logic [ID_WIDTH-1:0]           src_r_id,
  output logic                          src_r_last,
  output logic                          idle,
  output logic                          err_bad_rid
);

  typedef logic [7:0] cnt_t;
  localparam cnt_t MAX_CNT = cnt_t'(MAX_OUTSTANDING);

  cnt_t                   cnt_q [N_PORTS];
  cnt_t                   cnt_d [N_PORTS];
  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   ar_valid_q, ar_valid_d;
  logic [ADDR_WIDTH-1:0]  ar_addr_q, ar_addr_d;
  logic [PW+ID_WIDTH-1:0] ar_id_q, ar_id_d;
  logic [LEN_WIDTH-1:0]   ar_len_q, ar_len_d;
  logic                   idle_q, idle_d;
  logic                   err_q, err_d;

  logic                   load;
  logic [N_PORTS-1:0]     elig, grant, r_dec;
  logic [PW-1:0]          gidx, pos;
  logic [PW:0]            sum;
  logic                   any_grant;
  logic [PW-1:0]          r_idx;
  logic                   r_idx_ok;

  // Arbitration: first eligible port at or after the pointer, with wraparound.
  always_comb begin
    load      = !ar_valid_q || sink_ar_ready;
    grant     = '0;
    gidx      = '0;
    any_grant = 1'b0;
    sum       = '0;
    pos       = '0;
    for (int unsigned p = 0; p < N_PORTS; p++)
      elig[p] = src_ar_valid[p] && (cnt_q[p] < MAX_CNT);
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_PORTS)) sum = sum - (PW+1)'(N_PORTS);
      pos = sum[PW-1:0];
      if (load && !any_grant && elig[pos]) begin
        any_grant = 1'b1;
        grant[pos] = 1'b1;
        gidx       = pos;
      end
    end
    src_ar_ready = grant;
  end

  always_comb begin
    ptr_d      = ptr_q;
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    ar_id_d    = ar_id_q;
    ar_len_d   = ar_len_q;
    if (load) ar_valid_d = any_grant;
    if (any_grant) begin
      ptr_d     = (gidx == PW'(N_PORTS - 1)) ? '0 : gidx + 1'b1;
      ar_addr_d = src_ar_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
      ar_id_d   = {gidx, src_ar_id[gidx*ID_WIDTH +: ID_WIDTH]};
      ar_len_d  = src_ar_len[gidx*LEN_WIDTH +: LEN_WIDTH];
    end
  end

  // R routing: out-of-range indices are accepted and dropped.
  always_comb begin
    r_idx        = sink_r_id[PW+ID_WIDTH-1:ID_WIDTH];
    r_idx_ok     = (32'(r_idx) < N_PORTS);
    sink_r_ready = 1'b1;
    src_r_valid  = '0;
    r_dec        = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      if (r_idx == PW'(p)) begin
        sink_r_ready   = src_r_ready[p];
        src_r_valid[p] = sink_r_valid;
      end
    end
    for (int unsigned p = 0; p < N_PORTS; p++)
      r_dec[p] = sink_r_valid && sink_r_ready && sink_r_last && (r_idx == PW'(p));
    err_d = err_q || (sink_r_valid && !r_idx_ok);
  end

  always_comb begin
    idle_d = !ar_valid_d;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      cnt_d[p] = cnt_q[p];
      if (grant[p] && !r_dec[p])      cnt_d[p] = cnt_q[p] + 1'b1;
      else if (r_dec[p] && !grant[p]) cnt_d[p] = cnt_q[p] - 1'b1;
      if (cnt_d[p] != '0) idle_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < N_PORTS; p++) cnt_q[p] <= '0;
      ptr_q      <= '0;
      ar_valid_q <= 1'b0;
      idle_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < N_PORTS; p++) cnt_q[p] <= cnt_d[p];
      ptr_q      <= ptr_d;
      ar_valid_q <= ar_valid_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
    end
  end

  // Payload needs no reset: it is qualified by ar_valid_q.
  always_ff @(posedge clk) begin
    ar_addr_q <= ar_addr_d;
    ar_id_q   <= ar_id_d;
    ar_len_q  <= ar_len_d;
  end

  // Debug: a burst completion must never arrive for a port with no credit in use.
  always_ff @(posedge clk) begin
    if (reset_n)
      for (int unsigned p = 0; p < N_PORTS; p++)
        assert (!(r_dec[p] && !grant[p] && cnt_q[p] == '0));
  end

  assign sink_ar_valid = ar_valid_q;
  assign sink_ar_addr  = ar_addr_q;
  assign sink_ar_id    = ar_id_q;
  assign sink_ar_len   = ar_len_q;
  assign src_r_data    = sink_r_data;
  assign src_r_id      = sink_r_id[ID_WIDTH-1:0];
  assign src_r_last    = sink_r_last;
  assign idle          = idle_q;
  assign err_bad_rid   = err_q;

endmodule

// File: tb/tb_ofs_plat_host_chan_axi_rd_arb.sv
// Directed bench: a 4-port instance (routing, fairness, backpressure) and a
// 3-port, 2-credit instance (credit limit, bad RID, async reset).
module tb_ofs_plat_host_chan_axi_rd_arb;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: N_PORTS=4, MAX_OUTSTANDING=16
  logic [3:0]   a_src_ar_valid, a_src_ar_ready;
  logic [127:0] a_src_ar_addr;
  logic [31:0]  a_src_ar_id, a_src_ar_len;
  logic         a_sink_ar_valid, a_sink_ar_ready;
  logic [31:0]  a_sink_ar_addr;
  logic [9:0]   a_sink_ar_id;
  logic [7:0]   a_sink_ar_len;
  logic         a_sink_r_valid, a_sink_r_ready, a_sink_r_last;
  logic [31:0]  a_sink_r_data;
  logic [9:0]   a_sink_r_id;
  logic [3:0]   a_src_r_valid, a_src_r_ready;
  logic [31:0]  a_src_r_data;
  logic [7:0]   a_src_r_id;
  logic         a_src_r_last, a_idle, a_err;

  // Instance B: N_PORTS=3, MAX_OUTSTANDING=2
  logic [2:0]   b_src_ar_valid, b_src_ar_ready;
  logic [95:0]  b_src_ar_addr;
  logic [23:0]  b_src_ar_id, b_src_ar_len;
  logic         b_sink_ar_valid, b_sink_ar_ready;
  logic [31:0]  b_sink_ar_addr;
  logic [9:0]   b_sink_ar_id;
  logic [7:0]   b_sink_ar_len;
  logic         b_sink_r_valid, b_sink_r_ready, b_sink_r_last;
  logic [31:0]  b_sink_r_data;
  logic [9:0]   b_sink_r_id;
  logic [2:0]   b_src_r_valid, b_src_r_ready;
  logic [31:0]  b_src_r_data;
  logic [7:0]   b_src_r_id;
  logic         b_src_r_last, b_idle, b_err;

  ofs_plat_host_chan_axi_rd_arb #(
    .N_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8),
    .LEN_WIDTH(8), .MAX_OUTSTANDING(16)
  ) dut_a (
    .clk(clk), .reset_n(reset_n),
    .src_ar_valid(a_src_ar_valid), .src_ar_ready(a_src_ar_ready),
    .src_ar_addr(a_src_ar_addr), .src_ar_id(a_src_ar_id), .src_ar_len(a_src_ar_len),
    .sink_ar_valid(a_sink_ar_valid), .sink_ar_ready(a_sink_ar_ready),
    .sink_ar_addr(a_sink_ar_addr), .sink_ar_id(a_sink_ar_id), .sink_ar_len(a_sink_ar_len),
    .sink_r_valid(a_sink_r_valid), .sink_r_ready(a_sink_r_ready),
    .sink_r_data(a_sink_r_data), .sink_r_id(a_sink_r_id), .sink_r_last(a_sink_r_last),
    .src_r_valid(a_src_r_valid), .src_r_ready(a_src_r_ready),
    .src_r_data(a_src_r_data), .src_r_id(a_src_r_id), .src_r_last(a_src_r_last),
    .idle(a_idle), .err_bad_rid(a_err)
  );

  ofs_plat_host_chan_axi_rd_arb #(
    .N_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8),
    .LEN_WIDTH(8), .MAX_OUTSTANDING(2)
  ) dut_b (
    .clk(clk), .reset_n(reset_n),
    .src_ar_valid(b_src_ar_valid), .src_ar_ready(b_src_ar_ready),
    .src_ar_addr(b_src_ar_addr), .src_ar_id(b_src_ar_id), .src_ar_len(b_src_ar_len),
    .sink_ar_valid(b_sink_ar_valid), .sink_ar_ready(b_sink_ar_ready),
    .sink_ar_addr(b_sink_ar_addr), .sink_ar_id(b_sink_ar_id), .sink_ar_len(b_sink_ar_len),
    .sink_r_valid(b_sink_r_valid), .sink_r_ready(b_sink_r_ready),
    .sink_r_data(b_sink_r_data), .sink_r_id(b_sink_r_id), .sink_r_last(b_sink_r_last),
    .src_r_valid(b_src_r_valid), .src_r_ready(b_src_r_ready),
    .src_r_data(b_src_r_data), .src_r_id(b_src_r_id), .src_r_last(b_src_r_last),
    .idle(b_idle), .err_bad_rid(b_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ep;
    reset_n = 1'b0;
    a_src_ar_valid = '0; a_src_ar_addr = '0; a_src_ar_id = '0; a_src_ar_len = '0;
    a_sink_ar_ready = 1'b0; a_sink_r_valid = 1'b0; a_sink_r_data = '0;
    a_sink_r_id = '0; a_sink_r_last = 1'b0; a_src_r_ready = '0;
    b_src_ar_valid = '0; b_src_ar_addr = '0; b_src_ar_id = '0; b_src_ar_len = '0;
    b_sink_ar_ready = 1'b0; b_sink_r_valid = 1'b0; b_sink_r_data = '0;
    b_sink_r_id = '0; b_sink_r_last = 1'b0; b_src_r_ready = '0;

    step(); step();
    chk("rst_a_ar_valid", a_sink_ar_valid, 0);
    chk("rst_a_idle", a_idle, 1);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_ar_valid", b_sink_ar_valid, 0);
    chk("rst_b_idle", b_idle, 1);
    reset_n = 1'b1;
    step();
    chk("post_rst_idle", a_idle, 1);

    // Single port request on port 1
    a_sink_ar_ready = 1'b1;
    a_src_ar_valid = 4'b0010;
    a_src_ar_addr[32 +: 32] = 32'h1000;
    a_src_ar_id[8 +: 8] = 8'h05;
    a_src_ar_len[8 +: 8] = 8'd3;
    #1 chk("single_grant", a_src_ar_ready, 4'b0010);
    step();
    a_src_ar_valid = '0;
    chk("single_ar_valid", a_sink_ar_valid, 1);
    chk("single_ar_id", a_sink_ar_id, 10'h105);
    chk("single_ar_addr", a_sink_ar_addr, 32'h1000);
    chk("single_ar_len", a_sink_ar_len, 3);
    chk("single_busy", a_idle, 0);
    step();
    chk("single_ar_drop", a_sink_ar_valid, 0);
    a_src_r_ready = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      a_sink_r_valid = 1'b1;
      a_sink_r_id = 10'h105;
      a_sink_r_data = 32'hD0 + k;
      a_sink_r_last = (k == 3);
      #1;
      chk("single_r_valid", a_src_r_valid, 4'b0010);
      chk("single_r_ready", a_sink_r_ready, 1);
      chk("single_r_data", a_src_r_data, 32'hD0 + k);
      chk("single_r_id", a_src_r_id, 8'h05);
      step();
      if (k < 3) chk("single_mid_busy", a_idle, 0);
    end
    a_sink_r_valid = 1'b0;
    a_sink_r_last = 1'b0;
    chk("single_idle", a_idle, 1);

    // Fairness: pointer is at 2 after the port-1 grant
    for (int p = 0; p < 4; p++) begin
      a_src_ar_addr[p*32 +: 32] = 32'hA000 + p;
      a_src_ar_id[p*8 +: 8] = 8'h10 + 8'(p);
      a_src_ar_len[p*8 +: 8] = 8'(p);
    end
    a_src_ar_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      ep = (2 + i) % 4;
      #1 chk("fair_grant", a_src_ar_ready, 64'(1) << ep);
      step();
      chk("fair_ar_valid", a_sink_ar_valid, 1);
      chk("fair_ar_id", a_sink_ar_id, 64'(ep * 256 + 16 + ep));
    end

    // Backpressure with port 1's request held in the register
    a_sink_ar_ready = 1'b0;
    #1 chk("bp_no_grant0", a_src_ar_ready, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", a_sink_ar_valid, 1);
      chk("bp_addr", a_sink_ar_addr, 32'hA001);
      chk("bp_id", a_sink_ar_id, 10'h111);
      chk("bp_len", a_sink_ar_len, 1);
      chk("bp_no_grant", a_src_ar_ready, 0);
    end
    a_sink_ar_ready = 1'b1;
    #1 chk("bp_ptr_held", a_src_ar_ready, 4'b0100);
    step();
    a_src_ar_valid = '0;
    chk("bp_next_id", a_sink_ar_id, 10'h212);
    step();
    chk("bp_drain", a_sink_ar_valid, 0);

    // R routing with port 2 backpressured
    a_src_r_ready = 4'b1011;
    a_sink_r_valid = 1'b1;
    a_sink_r_id = 10'h211;
    a_sink_r_last = 1'b0;
    #1;
    chk("route_p2_ready", a_sink_r_ready, 0);
    chk("route_p2_valid", a_src_r_valid, 4'b0100);
    step();
    a_sink_r_id = 10'h022;
    a_sink_r_last = 1'b1;
    a_sink_r_data = 32'hCAFE;
    #1;
    chk("route_p0_valid", a_src_r_valid, 4'b0001);
    chk("route_p0_ready", a_sink_r_ready, 1);
    chk("route_p0_id", a_src_r_id, 8'h22);
    chk("route_p0_last", a_src_r_last, 1);
    step();
    a_src_r_ready = 4'b1111;
    a_sink_r_id = 10'h211;
    #1 chk("route_p2_release", a_sink_r_ready, 1);
    step();
    a_sink_r_valid = 1'b0;
    a_sink_r_last = 1'b0;

    // Credit limit on instance B (2 credits per port)
    b_sink_ar_ready = 1'b1;
    b_src_ar_addr[0 +: 32] = 32'hB000; b_src_ar_id[0 +: 8] = 8'h30; b_src_ar_len[0 +: 8] = 8'd7;
    b_src_ar_addr[64 +: 32] = 32'hB200; b_src_ar_id[16 +: 8] = 8'h32; b_src_ar_len[16 +: 8] = 8'd2;
    b_src_ar_valid = 3'b001;
    #1 chk("cred_g1", b_src_ar_ready, 3'b001);
    step();
    #1 chk("cred_g2", b_src_ar_ready, 3'b001);
    step();
    chk("cred_g2_id", b_sink_ar_id, 10'h030);
    b_src_ar_valid = 3'b101;
    #1 chk("cred_p2_granted", b_src_ar_ready, 3'b100);
    step();
    chk("cred_p2_id", b_sink_ar_id, 10'h232);
    b_src_ar_valid = 3'b001;
    b_sink_r_valid = 1'b1;
    b_sink_r_id = 10'h030;
    b_sink_r_last = 1'b1;
    b_src_r_ready = 3'b111;
    #1;
    chk("cred_stall", b_src_ar_ready, 3'b000);
    chk("cred_r_ready", b_sink_r_ready, 1);
    step();
    b_sink_r_valid = 1'b0;
    #1 chk("cred_regrant", b_src_ar_ready, 3'b001);
    step();
    b_src_ar_valid = '0;
    chk("cred_regrant_id", b_sink_ar_id, 10'h030);
    chk("cred_regrant_len", b_sink_ar_len, 7);

    // Bad RID index 3 on a 3-port instance
    b_sink_r_valid = 1'b1;
    b_sink_r_id = 10'h3AA;
    b_sink_r_last = 1'b1;
    b_src_r_ready = 3'b000;
    #1;
    chk("bad_ready", b_sink_r_ready, 1);
    chk("bad_no_valid", b_src_r_valid, 3'b000);
    chk("bad_err_pre", b_err, 0);
    step();
    b_sink_r_valid = 1'b0;
    b_sink_r_last = 1'b0;
    chk("bad_err_set", b_err, 1);
    step();
    chk("bad_err_held", b_err, 1);

    // Asynchronous reset with a request held in the register
    b_src_ar_valid = 3'b100;
    b_sink_ar_ready = 1'b1;
    step();
    b_src_ar_valid = '0;
    b_sink_ar_ready = 1'b0;
    chk("mid_ar_valid", b_sink_ar_valid, 1);
    chk("mid_busy", b_idle, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ar_valid", b_sink_ar_valid, 0);
    chk("arst_err", b_err, 0);
    chk("arst_idle_b", b_idle, 1);
    chk("arst_idle_a", a_idle, 1);
    step();
    reset_n = 1'b1;
    step();
    chk("after_rst_idle", b_idle, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
